bit_vector_comb_gen: RTL and testbench
======================================

# bit_vector_comb_gen

Sequential generator for the inverse of the bit-count function. Given a target count `k`, it emits every `DATA_W`-bit vector containing exactly `k` ones, one vector per handshake, in strictly ascending numeric order. It feeds exhaustive stimulus and enumeration paths that consume popcount-constrained vectors through a valid/ready stream.

## Interface
- `DATA_W`, default 8: width of generated vectors; legal range ≥ 2.
- `POS_W`, default `$clog2(DATA_W)`: `k` port is `POS_W+1` bits wide, so it can hold values 0..`DATA_W`.
- `clk`  input  1: single clock; all logic is on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `start`  input  1: request a new enumeration; sampled only in IDLE.
- `k`  input  `POS_W+1`: target number of ones; sampled with `start`.
- `busy`  output  1: high from the cycle after an accepted `start` until the last transfer completes.
- `err`  output  1: one-cycle pulse when a `start` is sampled with `k > DATA_W`.
- `out_valid`  output  1: `out_data` holds a valid vector.
- `out_ready`  input  1: consumer accepts the vector.
- `out_data`  output  `DATA_W`: current vector; its popcount equals the latched `k`.
- `out_last`  output  1: current vector is the final one of the enumeration.
- `out_idx`  output  `DATA_W`: 0-based index of the current vector within the enumeration.
- `done`  output  1: one-cycle pulse on the cycle after the last transfer.

## Operation
- States: IDLE and RUN.
- IDLE, `start`=1, `k` ≤ `DATA_W`:
  - latch `k`;
  - `out_data` ← (1<<k)−1;
  - `out_idx` ← 0;
  - `out_last` ← (k==0 || k==DATA_W);
  - `out_valid` ← 1, `busy` ← 1;
  - go to RUN.
- IDLE, `start`=1, `k` > `DATA_W`: `err` ← 1 for one cycle; stay in IDLE; no output activity.
- In RUN, `start` is ignored.
- A transfer occurs when `out_valid && out_ready`.
- Transfer with `out_last`=0: load the next vector by Gosper's step on x = `out_data`:
  - c = x & −x;
  - r = x + c;
  - next = r | (((r ^ x) >> 2) >> ctz(c)).
  - All arithmetic is `DATA_W` bits wide; the shift by ctz(c) replaces division by c.
  - `out_idx` increments by 1.
  - `out_last` ← (next == ((1<<k)−1) << (DATA_W−k)).
- Transfer with `out_last`=1:
  - `out_valid` ← 0, `busy` ← 0;
  - `done` ← 1 for one cycle;
  - return to IDLE.
- No transfer: `out_data`, `out_last` and `out_idx` hold stable while `out_valid`=1. `out_valid` never drops without a transfer.
- k=0 yields exactly one vector, all zeros, with `out_last`=1. k=`DATA_W` yields exactly one vector, all ones, with `out_last`=1.
- The total number of vectors equals C(`DATA_W`, k). The `out_idx` width of `DATA_W` bits always suffices.
- `out_data`, `out_last` and `out_idx` are registers; no combinational path from `out_ready` to any output.

## Timing
- Reset values:
  - state = IDLE;
  - `busy`, `err`, `out_valid`, `out_last`, `done` = 0;
  - `out_data` = 0, `out_idx` = 0.
- `rst` asserted mid-enumeration: all outputs return to reset values on the next edge. A `start` in the same cycle as `rst` is dropped.
- Latency: `start` sampled at edge t → first vector valid after edge t, i.e. visible during cycle t+1.
- Throughput: one vector per cycle while `out_ready` is held high.
- `done` is asserted in the cycle after the last transfer. `start` is accepted in that same cycle, since the state is already IDLE.
- `err` and `done` never assert in the same cycle.

## Test plan
- DATA_W=4, k=2, `out_ready`=1:
  - vectors 0011, 0101, 0110, 1001, 1010, 1100 on consecutive cycles;
  - `out_idx` 0..5;
  - `out_last` set only on 1100;
  - `done` pulses once, then `busy`=0.
- DATA_W=4:
  - k=0 → single vector 0000 with `out_last`=1;
  - k=4 → single vector 1111 with `out_last`=1.
- DATA_W=4, k=5 → `err` high for exactly one cycle; `out_valid` and `busy` stay 0.
- DATA_W=8, k=3, random `out_ready` backpressure:
  - exactly 56 transfers;
  - each vector has popcount 3;
  - vectors strictly ascending, first 0x07, last 0xE0;
  - `out_data` is stable during every stall.
- `start` pulsed with k=1 during RUN of a k=2 enumeration → ignored; the sequence completes unchanged.
- `rst` asserted at the 3rd vector of DATA_W=8, k=4 → next cycle all outputs are 0 and IDLE. A subsequent `start` with k=1 yields 0x01 first.

Source files
------------

// File: rtl/bit_vector_comb_gen.sv
// bit_vector_comb_gen
// Enumerates every DATA_W-bit vector with exactly k ones in ascending numeric
// order, one vector per accepted transfer on a valid/ready output stream.
// The successor of each vector is computed with Gosper's hack, using a
// trailing-zero count and a right shift in place of a division.
//
// Handshake: a transfer happens on a rising edge where out_valid && out_ready.
// While out_valid is high and no transfer occurs, out_data, out_idx and
// out_last hold their values, and out_valid only falls after a transfer.
// All outputs come from registers, so out_ready never reaches an output
// through combinational logic.

module bit_vector_comb_gen #(
    parameter int DATA_W = 8,
    parameter int POS_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [POS_W:0]    k,
    output logic              busy,
    output logic              err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [DATA_W-1:0] out_idx,
    output logic              done,
    output logic [0:0]        dbg_state
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Ones in bit positions [kk-1:0]; this is the smallest vector with kk ones.
    function automatic logic [DATA_W-1:0] low_mask(input logic [POS_W:0] kk);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            m[i] = (i < int'(kk));
        end
        return m;
    endfunction

    // Ones in the top kk bit positions; this is the largest vector with kk ones.
    function automatic logic [DATA_W-1:0] high_mask(input logic [POS_W:0] kk);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++) begin
            m[i] = (i >= (DATA_W - int'(kk)));
        end
        return m;
    endfunction

    // Number of trailing zeros; returns DATA_W for an all-zero input.
    function automatic logic [POS_W:0] ctz(input logic [DATA_W-1:0] v);
        logic [POS_W:0] r;
        r = (POS_W + 1)'(DATA_W);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = (POS_W + 1)'(i);
            end
        end
        return r;
    endfunction

    logic [0:0]        state_q,     state_d;
    logic              busy_q,      busy_d;
    logic              err_q,       err_d;
    logic              valid_q,     valid_d;
    logic              last_q,      last_d;
    logic              done_q,      done_d;
    logic [DATA_W-1:0] data_q,      data_d;
    logic [DATA_W-1:0] idx_q,       idx_d;
    logic [DATA_W-1:0] last_pat_q,  last_pat_d;

    logic [DATA_W-1:0] gos_c;
    logic [DATA_W-1:0] gos_r;
    logic [POS_W:0]    gos_sh;
    logic [DATA_W-1:0] gos_next;
    logic              xfer;

    // Gosper's step on the current vector: lowest set bit, ripple, refill.
    always_comb begin
        gos_c    = data_q & (~data_q + DATA_W'(1));
        gos_r    = data_q + gos_c;
        gos_sh   = ctz(gos_c);
        gos_next = gos_r | (((gos_r ^ data_q) >> 2) >> gos_sh);
    end

    assign xfer = valid_q && out_ready;

    // Next-state logic for the IDLE/RUN controller and the output registers.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        err_d      = 1'b0;
        done_d     = 1'b0;
        valid_d    = valid_q;
        last_d     = last_q;
        data_d     = data_q;
        idx_d      = idx_q;
        last_pat_d = last_pat_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (int'(k) > DATA_W) begin
                        err_d = 1'b1;
                    end else begin
                        data_d     = low_mask(k);
                        last_pat_d = high_mask(k);
                        idx_d      = '0;
                        last_d     = (k == '0) || (k == (POS_W + 1)'(DATA_W));
                        valid_d    = 1'b1;
                        busy_d     = 1'b1;
                        state_d    = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        data_d = gos_next;
                        idx_d  = idx_q + DATA_W'(1);
                        last_d = (gos_next == last_pat_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            data_q     <= '0;
            idx_q      <= '0;
            last_pat_q <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            last_pat_q <= last_pat_d;
        end
    end

    assign busy      = busy_q;
    assign err       = err_q;
    assign done      = done_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bit_vector_comb_gen.sv
// Bench for bit_vector_comb_gen: one 4-bit and one 8-bit instance share the
// clock and reset. Expected {last, idx, data} entries are queued per instance
// and a negedge monitor compares them against the stream.

module tb_bit_vector_comb_gen;

    localparam int EXP_W = 17;

    logic clk;
    logic rst;

    logic        start4, out_ready4;
    logic [2:0]  k4;
    logic        busy4, err4, ov4, ol4, done4;
    logic [3:0]  od4, oi4;
    logic [0:0]  st4;

    logic        start8, out_ready8;
    logic [3:0]  k8;
    logic        busy8, err8, ov8, ol8, done8;
    logic [7:0]  od8, oi8;
    logic [0:0]  st8;

    logic [EXP_W-1:0] exp4_q[$];
    logic [EXP_W-1:0] exp8_q[$];

    int n_vec;
    int n_bad;
    int done4_cnt, err4_cnt, done8_cnt, err8_cnt, xfer8_cnt;
    logic mon_en;

    bit_vector_comb_gen #(.DATA_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .k(k4),
        .busy(busy4), .err(err4), .out_valid(ov4), .out_ready(out_ready4),
        .out_data(od4), .out_last(ol4), .out_idx(oi4), .done(done4),
        .dbg_state(st4)
    );

    bit_vector_comb_gen #(.DATA_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .k(k8),
        .busy(busy8), .err(err8), .out_valid(ov8), .out_ready(out_ready8),
        .out_data(od8), .out_last(ol8), .out_idx(oi8), .done(done8),
        .dbg_state(st8)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [EXP_W-1:0] pack4(input logic l, input logic [3:0] i, input logic [3:0] d);
        return {8'b0, l, i, d};
    endfunction

    function automatic logic [EXP_W-1:0] pack8(input logic l, input logic [7:0] i, input logic [7:0] d);
        return {l, i, d};
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp4_q.size() == 0) begin
                check("dut4_valid_with_nothing_expected", {31'b0, ov4}, 32'd0);
            end else if (ov4 === 1'b1) begin
                check("dut4_stream", {15'b0, pack4(ol4, oi4, od4)}, {15'b0, exp4_q[0]});
                if (out_ready4) void'(exp4_q.pop_front());
            end
            if (exp8_q.size() == 0) begin
                check("dut8_valid_with_nothing_expected", {31'b0, ov8}, 32'd0);
            end else if (ov8 === 1'b1) begin
                check("dut8_stream", {15'b0, pack8(ol8, oi8, od8)}, {15'b0, exp8_q[0]});
                if (out_ready8) begin
                    void'(exp8_q.pop_front());
                    xfer8_cnt++;
                end
            end
            check("dut4_err_done_overlap", {31'b0, err4 & done4}, 32'd0);
            check("dut8_err_done_overlap", {31'b0, err8 & done8}, 32'd0);
            if (done4 === 1'b1) done4_cnt++;
            if (err4 === 1'b1) err4_cnt++;
            if (done8 === 1'b1) done8_cnt++;
            if (err8 === 1'b1) err8_cnt++;
        end
    end

    // Driver tasks (called at posedge + 1)
    task automatic pulse_start4(input logic [2:0] kk);
        start4 = 1'b1;
        k4     = kk;
        @(posedge clk); #1;
        start4 = 1'b0;
    endtask

    task automatic pulse_start8(input logic [3:0] kk);
        start8 = 1'b1;
        k8     = kk;
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic drain4(input string name, input int done_before);
        int cyc;
        for (cyc = 0; cyc < 200; cyc++) begin
            if (exp4_q.size() == 0 && ov4 === 1'b0) break;
            @(posedge clk); #1;
        end
        check({name, "_drained_in_budget"}, {31'b0, cyc < 200}, 32'd1);
        check({name, "_done_now"}, {31'b0, done4}, 32'd1);
        @(negedge clk); #1;
        check({name, "_done_pulses"}, done4_cnt - done_before, 32'd1);
        check({name, "_busy_after"}, {31'b0, busy4}, 32'd0);
        @(posedge clk); #1;
        check({name, "_done_dropped"}, {31'b0, done4}, 32'd0);
        check({name, "_state_idle"}, {31'b0, st4}, 32'd0);
    endtask

    task automatic drain8(input string name, input int done_before, input bit rnd_ready);
        int cyc;
        for (cyc = 0; cyc < 2000; cyc++) begin
            if (exp8_q.size() == 0 && ov8 === 1'b0) break;
            if (rnd_ready) out_ready8 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        check({name, "_drained_in_budget"}, {31'b0, cyc < 2000}, 32'd1);
        @(negedge clk); #1;
        check({name, "_done_pulses"}, done8_cnt - done_before, 32'd1);
        check({name, "_busy_after"}, {31'b0, busy8}, 32'd0);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
    endtask

    // Stimulus
    initial begin
        logic [3:0] tbl_k2[6];
        logic [7:0] vv;
        logic [7:0] one_hot;
        int idx;
        int d_before;
        int e_before;

        tbl_k2 = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC};
        n_vec = 0; n_bad = 0;
        done4_cnt = 0; err4_cnt = 0; done8_cnt = 0; err8_cnt = 0; xfer8_cnt = 0;
        mon_en = 1'b0;
        rst = 1'b1;
        start4 = 1'b0; k4 = '0; out_ready4 = 1'b0;
        start8 = 1'b0; k8 = '0; out_ready8 = 1'b0;

        // Reset state
        @(posedge clk); #1;
        check("rst_dut4_outputs", {21'b0, busy4, err4, ov4, ol4, done4, od4, oi4, st4}, 32'd0);
        check("rst_dut8_outputs", {11'b0, busy8, err8, ov8, ol8, done8, od8, oi8, st8}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // DATA_W=4, k=2, ready held high
        for (int i = 0; i < 6; i++) exp4_q.push_back(pack4(i == 5, 4'(i), tbl_k2[i]));
        out_ready4 = 1'b1;
        d_before = done4_cnt;
        pulse_start4(3'd2);
        check("k2_busy_during_run", {31'b0, busy4}, 32'd1);
        drain4("k2_run", d_before);

        // DATA_W=4, k=0 and k=4
        exp4_q.push_back(pack4(1'b1, 4'd0, 4'h0));
        d_before = done4_cnt;
        pulse_start4(3'd0);
        drain4("k0_run", d_before);

        exp4_q.push_back(pack4(1'b1, 4'd0, 4'hF));
        d_before = done4_cnt;
        pulse_start4(3'd4);
        drain4("k4_run", d_before);

        // DATA_W=4, k=5 is rejected
        e_before = err4_cnt;
        d_before = done4_cnt;
        pulse_start4(3'd5);
        check("k5_err_now", {31'b0, err4}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("k5_busy_low", {31'b0, busy4}, 32'd0);
            check("k5_valid_low", {31'b0, ov4}, 32'd0);
            @(posedge clk); #1;
        end
        check("k5_err_cycles", err4_cnt - e_before, 32'd1);
        check("k5_no_done", done4_cnt - d_before, 32'd0);

        // start with k=1 during a stalled k=2 run is ignored
        for (int i = 0; i < 6; i++) exp4_q.push_back(pack4(i == 5, 4'(i), tbl_k2[i]));
        out_ready4 = 1'b0;
        d_before = done4_cnt;
        pulse_start4(3'd2);
        @(posedge clk); #1;
        start4 = 1'b1; k4 = 3'd1;
        @(posedge clk); #1;
        start4 = 1'b0;
        out_ready4 = 1'b1;
        drain4("ignored_start_run", d_before);

        // DATA_W=8, k=3 with random backpressure
        idx = 0;
        for (int v = 0; v < 256; v++) begin
            vv = v[7:0];
            if ($countones(vv) == 3) begin
                exp8_q.push_back(pack8(vv == 8'hE0, 8'(idx), vv));
                idx++;
            end
        end
        check("k3_model_count", exp8_q.size(), 32'd56);
        xfer8_cnt = 0;
        d_before = done8_cnt;
        out_ready8 = 1'b0;
        pulse_start8(4'd3);
        drain8("k3_backpressure", d_before, 1'b1);
        check("k3_transfers", xfer8_cnt, 32'd56);

        // Reset during the third vector of DATA_W=8, k=4
        exp8_q.push_back(pack8(1'b0, 8'd0, 8'h0F));
        exp8_q.push_back(pack8(1'b0, 8'd1, 8'h17));
        exp8_q.push_back(pack8(1'b0, 8'd2, 8'h1B));
        out_ready8 = 1'b1;
        pulse_start8(4'd4);
        idx = 0;
        while (idx < 20 && !(ov8 === 1'b1 && oi8 == 8'd2)) begin
            @(posedge clk); #1;
            idx++;
        end
        check("rst_test_reached_third", {31'b0, idx < 20}, 32'd1);
        rst = 1'b1;
        out_ready8 = 1'b0;
        start8 = 1'b1;
        k8 = 4'd1;
        @(posedge clk); #1;
        rst = 1'b0;
        start8 = 1'b0;
        exp8_q.delete();
        check("midrun_rst_outputs", {11'b0, busy8, err8, ov8, ol8, done8, od8, oi8, st8}, 32'd0);
        @(posedge clk); #1;
        check("midrun_rst_start_dropped", {30'b0, ov8, busy8}, 32'd0);

        // Fresh k=1 enumeration after the reset
        for (int i = 0; i < 8; i++) begin
            one_hot = 8'(1 << i);
            exp8_q.push_back(pack8(i == 7, 8'(i), one_hot));
        end
        d_before = done8_cnt;
        out_ready8 = 1'b1;
        pulse_start8(4'd1);
        check("k1_first_vector", {24'b0, od8}, 32'h01);
        drain8("k1_after_rst", d_before, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
